// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Brief    : Moore control FSM for a multicycle MIPS-style datapath.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter logic [3:0] ALU_ADD = 4'b0000,
  parameter logic [5:0] HALT_OP = 6'b111111,
  parameter int         CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [5:0]       Opcode,
  output logic             MemWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUOp,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic [1:0]       Branch,
  output logic             RegSrc,
  output logic             RegWrite,
  output logic             SN,
  output logic [3:0]       State,
  output logic             Halted,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [3:0] c_INIT   = 4'd0;
  localparam logic [3:0] c_FETCH  = 4'd1;
  localparam logic [3:0] c_DECODE = 4'd2;
  localparam logic [3:0] c_EXEC_R = 4'd3;
  localparam logic [3:0] c_EXEC_I = 4'd4;
  localparam logic [3:0] c_WB_ALU = 4'd5;
  localparam logic [3:0] c_MEM_RD = 4'd6;
  localparam logic [3:0] c_WB_MEM = 4'd7;
  localparam logic [3:0] c_MEM_WR = 4'd8;
  localparam logic [3:0] c_BRANCH = 4'd9;
  localparam logic [3:0] c_JUMP   = 4'd10;
  localparam logic [3:0] c_HALT   = 4'd11;

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       r_state;
  logic [3:0]       r_func;
  logic             r_op5;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       w_next;
  logic             w_retire;

  // Only the opcode fields needed after DECODE are held, so later IR changes are ignored.
  always_comb begin
    w_next = c_FETCH;
    case (r_state)
      c_INIT:   w_next = c_FETCH;
      c_FETCH:  w_next = c_DECODE;
      c_DECODE: begin
        if (Opcode == HALT_OP) begin
          w_next = c_HALT;
        end else begin
          casez (Opcode)
            6'b00????: w_next = c_EXEC_R;
            6'b01????: w_next = c_EXEC_I;
            6'b100000: w_next = c_MEM_RD;
            6'b100001: w_next = c_MEM_WR;
            6'b100010: w_next = c_BRANCH;
            6'b100011: w_next = c_BRANCH;
            6'b110000: w_next = c_JUMP;
            default:   w_next = c_FETCH;
          endcase
        end
      end
      c_EXEC_R: w_next = c_WB_ALU;
      c_EXEC_I: w_next = c_WB_ALU;
      c_WB_ALU: w_next = c_FETCH;
      c_MEM_RD: w_next = c_WB_MEM;
      c_WB_MEM: w_next = c_FETCH;
      c_MEM_WR: w_next = c_FETCH;
      c_BRANCH: w_next = c_FETCH;
      c_JUMP:   w_next = c_FETCH;
      c_HALT:   w_next = c_HALT;
      default:  w_next = c_INIT;
    endcase
  end

  assign w_retire = (w_next == c_FETCH) && (r_state != c_INIT);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= c_INIT;
      r_func  <= 4'b0000;
      r_op5   <= 1'b0;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_next;
      if (r_state == c_DECODE) begin
        r_func <= Opcode[3:0];
        r_op5  <= Opcode[5];
      end
      if (w_retire) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
    end
  end

  always_comb begin
    MemWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 4'b0000;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 2'b00;
    Branch   = 2'b00;
    RegSrc   = 1'b0;
    RegWrite = 1'b0;
    SN       = 1'b0;
    Halted   = 1'b0;
    case (r_state)
      c_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = ALU_ADD;
      end
      c_DECODE: begin
        ALUSrcB = 2'b10;
        ALUOp   = ALU_ADD;
        SN      = ~Opcode[5];
      end
      c_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = r_func;
        SN      = ~r_op5;
      end
      c_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = r_func;
        SN      = ~r_op5;
      end
      c_WB_ALU: begin
        RegWrite = 1'b1;
        SN       = ~r_op5;
      end
      c_WB_MEM: begin
        RegWrite = 1'b1;
        RegSrc   = 1'b1;
      end
      c_MEM_WR: MemWrite = 1'b1;
      // BZ and BNZ differ only in opcode bit 0.
      c_BRANCH: begin
        PCSrc  = 2'b01;
        Branch = r_func[0] ? 2'b10 : 2'b01;
      end
      c_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      c_HALT:  Halted = 1'b1;
      default: Halted = 1'b0;
    endcase
  end

  assign State      = r_state;
  assign InstrCount = r_cnt;

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM that drives every control input of the multicycle MIPS-style datapath.
- Consumes the 6-bit opcode presented by the datapath's instruction register and sequences fetch, decode, execute, memory and writeback.
- Also provides a halt flag, a state-debug output and a retired-instruction counter for the bench and top level.

Parameters:
- ALU_ADD, 4'b0000, ALUOp code for addition; used for PC increment and branch-target computation.
- HALT_OP, 6'b111111, opcode that parks the FSM in HALT.
- CNT_W, 16, width of InstrCount.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low.
- Opcode  input  6  instruction-register opcode from the datapath.
- MemWrite  output  1  data-memory write enable.
- ALUSrcA  output  1  0 = PC, 1 = A register.
- ALUSrcB  output  2  00 = B register, 01 = constant 1, 10 = extended immediate.
- ALUOp  output  4  ALU operation.
- IRWrite  output  1  instruction-register load.
- PCWrite  output  1  unconditional PC load.
- PCSrc  output  2  00 = ALU result, 01 = ALUOut register, 10 = jump field.
- Branch  output  2  [0] = branch-if-zero, [1] = branch-if-nonzero.
- RegSrc  output  1  0 = ALUOut, 1 = memory data register.
- RegWrite  output  1  register-file write enable.
- SN  output  1  read-port-1 select: 0 = R1 field, 1 = R2 field.
- State  output  4  current state encoding, for debug.
- Halted  output  1  high while in HALT.
- InstrCount  output  CNT_W  retired-instruction count.

Behaviour:
- Reset asserted (Reset = 0), asynchronously:
  - State goes to INIT and InstrCount goes to 0.
  - All outputs are 0 while in INIT.
  - The first rising edge after Reset returns high moves the FSM to FETCH.
- Outputs are decoded combinationally from the state register and Opcode; every signal not listed for a state is 0.
- Opcode classes:
  - 00xxxx: R-type.
  - 01xxxx: I-type ALU.
  - 100000: LW.
  - 100001: SW.
  - 100010: BZ.
  - 100011: BNZ.
  - 110000: J.
  - HALT_OP: halt.
  - Any other opcode is a NOP.
- SN: 1 in DECODE/EXEC_R/EXEC_I/WB_ALU when Opcode[5] = 0; otherwise 0.
- States and transitions:
  - INIT: outputs all 0 -> FETCH.
  - FETCH: IRWrite = 1, PCWrite = 1, ALUSrcA = 0, ALUSrcB = 01, ALUOp = ALU_ADD, PCSrc = 00 -> DECODE.
  - DECODE: ALUSrcA = 0, ALUSrcB = 10, ALUOp = ALU_ADD, so ALUOut holds the branch target. Next state by opcode:
    - R-type -> EXEC_R.
    - I-type -> EXEC_I.
    - LW -> MEM_RD.
    - SW -> MEM_WR.
    - BZ/BNZ -> BRANCH.
    - J -> JUMP.
    - HALT_OP -> HALT.
    - NOP -> FETCH.
  - EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUOp = Opcode[3:0] -> WB_ALU.
  - EXEC_I: ALUSrcA = 1, ALUSrcB = 10, ALUOp = Opcode[3:0] -> WB_ALU.
  - WB_ALU: RegWrite = 1, RegSrc = 0 -> FETCH.
  - MEM_RD: all outputs 0, while the memory data register captures the read -> WB_MEM.
  - WB_MEM: RegWrite = 1, RegSrc = 1 -> FETCH.
  - MEM_WR: MemWrite = 1 for exactly one cycle -> FETCH.
  - BRANCH: PCSrc = 01, with Branch = 01 for BZ or 10 for BNZ. The datapath qualifies the PC load with zero/nonzero of A -> FETCH.
  - JUMP: PCWrite = 1, PCSrc = 10 -> FETCH.
  - HALT: Halted = 1, all enables 0; stays in HALT until Reset.
- Latency in cycles, counted from FETCH:
  - NOP: 2.
  - BZ, BNZ, J, SW: 3.
  - R-type, I-type, LW: 4.
- Opcode is sampled only in DECODE. Opcode changes in any other state have no effect.
- InstrCount increments by 1 on every transition into FETCH from any state except INIT, and wraps at 2^CNT_W. It does not increment entering HALT.
- At most one of RegWrite, MemWrite and PCWrite is high in any cycle. IRWrite is high only in FETCH.
- Reset asserted in any state, including mid-MEM_WR: outputs go to 0 immediately and asynchronously, with no partial write held over.

Test Plan:
- Reset released, Opcode = 000000 (R-type ADD) -> state sequence INIT, FETCH, DECODE, EXEC_R, WB_ALU, FETCH. ALUOp = 0000 and SN = 1 in EXEC_R; RegWrite = 1 for exactly one cycle; InstrCount = 1.
- Opcode = 100000 (LW) -> DECODE, MEM_RD, WB_MEM. WB_MEM has RegSrc = 1 and RegWrite = 1; MemWrite stays 0 throughout.
- Opcode = 100010 then 100011 -> BRANCH state shows Branch = 01, then Branch = 10; PCSrc = 01 and PCWrite = 0 in both.
- Opcode = 110000 -> JUMP with PCSrc = 10 and PCWrite = 1, then FETCH. Opcode = 101111 (NOP) -> DECODE goes directly to FETCH.
- Opcode = 111111 -> HALT with Halted = 1 and all enables 0 for 20 cycles; InstrCount is frozen. Reset pulse -> INIT, then FETCH.
- Reset asserted mid-MEM_WR, asynchronously between clock edges -> MemWrite drops the same instant and InstrCount = 0. Separately, CNT_W = 4 with 16 NOPs -> InstrCount wraps to 0.
